// File: rtl/id_ex_latch.sv
// id_ex_latch: dual-lane ID/EX pipeline register that splits dependent pairs via a one-entry lane B skid.
// Ports: clock, reset (async active-low); a_*/b_* decoded lane inputs; stall, flush;
//        ex_a_*/ex_b_* registered lanes; id_hold (comb, upstream hold); split_count (saturating).
module id_ex_latch (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic        b_valid,
  input  logic [10:0] a_ctrl,
  input  logic [10:0] b_ctrl,
  input  logic [31:0] a_pc,
  input  logic [31:0] b_pc,
  input  logic [31:0] a_rs_data,
  input  logic [31:0] a_rt_data,
  input  logic [31:0] b_rs_data,
  input  logic [31:0] b_rt_data,
  input  logic [31:0] a_imm,
  input  logic [31:0] b_imm,
  input  logic [4:0]  a_rd,
  input  logic [4:0]  b_rs,
  input  logic [4:0]  b_rt,
  input  logic [4:0]  b_rd,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_a_valid,
  output logic [10:0] ex_a_ctrl,
  output logic [31:0] ex_a_pc,
  output logic [31:0] ex_a_rs_data,
  output logic [31:0] ex_a_rt_data,
  output logic [31:0] ex_a_imm,
  output logic [4:0]  ex_a_rd,
  output logic        ex_b_valid,
  output logic [10:0] ex_b_ctrl,
  output logic [31:0] ex_b_pc,
  output logic [31:0] ex_b_rs_data,
  output logic [31:0] ex_b_rt_data,
  output logic [31:0] ex_b_imm,
  output logic [4:0]  ex_b_rd,
  output logic        id_hold,
  output logic [15:0] split_count
);
  typedef struct packed {
    logic        valid;
    logic [10:0] ctrl;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rd;
  } lane_t;
  typedef enum logic {PAIR, SPLIT} state_t;
  state_t      state_q, state_d;
  lane_t       a_in, b_in, ex_a_q, ex_a_d, ex_b_q, ex_b_d, skid_q, skid_d;
  logic [15:0] split_count_q, split_count_d;
  logic        raw, mem2, cf, split;
  // ctrl is masked by valid so an invalid lane never carries live control bits
  assign a_in = '{valid: a_valid, ctrl: a_ctrl & {11{a_valid}}, pc: a_pc,
                  rs_data: a_rs_data, rt_data: a_rt_data, imm: a_imm, rd: a_rd};
  assign b_in = '{valid: b_valid, ctrl: b_ctrl & {11{b_valid}}, pc: b_pc,
                  rs_data: b_rs_data, rt_data: b_rt_data, imm: b_imm, rd: b_rd};
  assign raw   = a_ctrl[10] && a_rd != 5'd0 && (a_rd == b_rs || a_rd == b_rt);
  assign mem2  = |a_ctrl[3:2] && |b_ctrl[3:2];
  assign cf    = |a_ctrl[8:4];
  assign split = a_valid && b_valid && (raw || mem2 || cf);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q       <= PAIR;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      skid_q        <= '0;
      split_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ex_a_q        <= ex_a_d;
      ex_b_q        <= ex_b_d;
      skid_q        <= skid_d;
      split_count_q <= split_count_d;
    end
  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = PAIR;
    else if (!stall)
      state_d = (state_q == PAIR && split) ? SPLIT : PAIR;
  end
  always_comb begin
    ex_a_d        = ex_a_q;
    ex_b_d        = ex_b_q;
    skid_d        = skid_q;
    split_count_d = split_count_q;
    if (flush) begin
      ex_a_d = '0;
      ex_b_d = '0;
      skid_d = '0;
    end else if (!stall) begin
      if (state_q == SPLIT) begin
        ex_a_d = skid_q;
        ex_b_d = '0;
        skid_d = '0;
      end else begin
        ex_a_d        = a_in;
        ex_b_d        = split ? '0 : b_in;
        skid_d        = split ? b_in : '0;
        split_count_d = split_count_q + {15'd0, split && split_count_q != 16'hFFFF};
      end
    end
  end
  // upstream already holds on stall, and flush discards the pair, so neither needs id_hold
  always_comb id_hold = state_q == PAIR && split && !stall && !flush;
  assign ex_a_valid   = ex_a_q.valid;
  assign ex_a_ctrl    = ex_a_q.ctrl;
  assign ex_a_pc      = ex_a_q.pc;
  assign ex_a_rs_data = ex_a_q.rs_data;
  assign ex_a_rt_data = ex_a_q.rt_data;
  assign ex_a_imm     = ex_a_q.imm;
  assign ex_a_rd      = ex_a_q.rd;
  assign ex_b_valid   = ex_b_q.valid;
  assign ex_b_ctrl    = ex_b_q.ctrl;
  assign ex_b_pc      = ex_b_q.pc;
  assign ex_b_rs_data = ex_b_q.rs_data;
  assign ex_b_rt_data = ex_b_q.rt_data;
  assign ex_b_imm     = ex_b_q.imm;
  assign ex_b_rd      = ex_b_q.rd;
  assign split_count  = split_count_q;
endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: directed self-checking bench for id_ex_latch.
module tb_id_ex_latch;
  logic        clock, reset, a_valid, b_valid, stall, flush;
  logic [10:0] a_ctrl, b_ctrl;
  logic [31:0] a_pc, b_pc, a_rs_data, a_rt_data, b_rs_data, b_rt_data, a_imm, b_imm;
  logic [4:0]  a_rd, b_rs, b_rt, b_rd;
  logic        ex_a_valid, ex_b_valid, id_hold;
  logic [10:0] ex_a_ctrl, ex_b_ctrl;
  logic [31:0] ex_a_pc, ex_a_rs_data, ex_a_rt_data, ex_a_imm;
  logic [31:0] ex_b_pc, ex_b_rs_data, ex_b_rt_data, ex_b_imm;
  logic [4:0]  ex_a_rd, ex_b_rd;
  logic [15:0] split_count;
  int          n_cmp = 0, n_err = 0;
  localparam logic [10:0] ADD = 11'h400, LW = 11'h60A, SW = 11'h204, JAL = 11'h410, BNE = 11'h100;
  id_ex_latch dut (
    .clock(clock), .reset(reset), .a_valid(a_valid), .b_valid(b_valid),
    .a_ctrl(a_ctrl), .b_ctrl(b_ctrl), .a_pc(a_pc), .b_pc(b_pc),
    .a_rs_data(a_rs_data), .a_rt_data(a_rt_data), .b_rs_data(b_rs_data), .b_rt_data(b_rt_data),
    .a_imm(a_imm), .b_imm(b_imm), .a_rd(a_rd), .b_rs(b_rs), .b_rt(b_rt), .b_rd(b_rd),
    .stall(stall), .flush(flush),
    .ex_a_valid(ex_a_valid), .ex_a_ctrl(ex_a_ctrl), .ex_a_pc(ex_a_pc),
    .ex_a_rs_data(ex_a_rs_data), .ex_a_rt_data(ex_a_rt_data), .ex_a_imm(ex_a_imm), .ex_a_rd(ex_a_rd),
    .ex_b_valid(ex_b_valid), .ex_b_ctrl(ex_b_ctrl), .ex_b_pc(ex_b_pc),
    .ex_b_rs_data(ex_b_rs_data), .ex_b_rt_data(ex_b_rt_data), .ex_b_imm(ex_b_imm), .ex_b_rd(ex_b_rd),
    .id_hold(id_hold), .split_count(split_count)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic set_a(input logic v, input logic [10:0] c, input logic [4:0] rd, input logic [31:0] pc);
    a_valid = v; a_ctrl = c; a_rd = rd; a_pc = pc;
    a_rs_data = pc + 1; a_rt_data = pc + 2; a_imm = pc + 3;
  endtask
  task automatic set_b(input logic v, input logic [10:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] pc);
    b_valid = v; b_ctrl = c; b_rs = rs; b_rt = rt; b_rd = rd; b_pc = pc;
    b_rs_data = pc + 1; b_rt_data = pc + 2; b_imm = pc + 3;
  endtask
  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0, '0, '0);
    #2;
    check("rst_a_valid", ex_a_valid, 0);
    check("rst_b_valid", ex_b_valid, 0);
    check("rst_count", split_count, 0);
    tick; tick;
    reset = 1'b1;
    // independent pair
    set_a(1'b1, ADD, 5'd3, 32'h100);
    set_b(1'b1, ADD, 5'd4, 5'd5, 5'd6, 32'h104);
    #1 check("ind_hold", id_hold, 0);
    tick;
    check("ind_a_valid", ex_a_valid, 1);
    check("ind_b_valid", ex_b_valid, 1);
    check("ind_a_pc", ex_a_pc, 32'h100);
    check("ind_b_pc", ex_b_pc, 32'h104);
    check("ind_b_ctrl", ex_b_ctrl, ADD);
    check("ind_b_rt_data", ex_b_rt_data, 32'h106);
    check("ind_count", split_count, 0);
    // RAW split
    set_a(1'b1, ADD, 5'd3, 32'h200);
    set_b(1'b1, ADD, 5'd3, 5'd7, 5'd8, 32'h204);
    #1 check("raw_hold", id_hold, 1);
    tick;
    check("raw_e1_a_pc", ex_a_pc, 32'h200);
    check("raw_e1_b_valid", ex_b_valid, 0);
    check("raw_e1_b_ctrl", ex_b_ctrl, 0);
    check("raw_e1_count", split_count, 1);
    check("raw_e1_hold", id_hold, 0);
    tick;
    check("raw_e2_a_pc", ex_a_pc, 32'h204);
    check("raw_e2_a_rd", ex_a_rd, 8);
    check("raw_e2_a_imm", ex_a_imm, 32'h207);
    check("raw_e2_a_valid", ex_a_valid, 1);
    check("raw_e2_a_ctrl", ex_a_ctrl, ADD);
    check("raw_e2_b_valid", ex_b_valid, 0);
    // rd = 0 never creates a dependency
    set_a(1'b1, ADD, 5'd0, 32'h300);
    set_b(1'b1, ADD, 5'd0, 5'd0, 5'd9, 32'h304);
    #1 check("rd0_hold", id_hold, 0);
    tick;
    check("rd0_b_valid", ex_b_valid, 1);
    check("rd0_b_pc", ex_b_pc, 32'h304);
    check("rd0_count", split_count, 1);
    // two memory ops
    set_a(1'b1, LW, 5'd11, 32'h400);
    set_b(1'b1, SW, 5'd9, 5'd10, 5'd0, 32'h404);
    #1 check("mem_hold", id_hold, 1);
    tick;
    check("mem_count", split_count, 2);
    check("mem_b_valid", ex_b_valid, 0);
    check("mem_a_ctrl", ex_a_ctrl, LW);
    tick;
    check("mem_e2_a_pc", ex_a_pc, 32'h404);
    check("mem_e2_a_ctrl", ex_a_ctrl, SW);
    // control flow in lane A
    set_a(1'b1, JAL, 5'd31, 32'h500);
    set_b(1'b1, ADD, 5'd1, 5'd2, 5'd12, 32'h504);
    #1 check("jal_hold", id_hold, 1);
    tick;
    check("jal_count", split_count, 3);
    tick;
    check("jal_e2_a_pc", ex_a_pc, 32'h504);
    // branch with invalid lane B: no split, lane B ctrl masked
    set_a(1'b1, BNE, 5'd0, 32'h600);
    set_b(1'b0, ADD, 5'd1, 5'd2, 5'd3, 32'h604);
    #1 check("bne_hold", id_hold, 0);
    tick;
    check("bne_a_valid", ex_a_valid, 1);
    check("bne_b_valid", ex_b_valid, 0);
    check("bne_b_ctrl", ex_b_ctrl, 0);
    check("bne_count", split_count, 3);
    // invalid lane A with a would-be RAW: lane B issues in ex_b
    set_a(1'b0, ADD, 5'd3, 32'h700);
    set_b(1'b1, ADD, 5'd3, 5'd3, 5'd4, 32'h704);
    #1 check("ainv_hold", id_hold, 0);
    tick;
    check("ainv_a_valid", ex_a_valid, 0);
    check("ainv_a_ctrl", ex_a_ctrl, 0);
    check("ainv_b_valid", ex_b_valid, 1);
    check("ainv_b_pc", ex_b_pc, 32'h704);
    // stall then flush+stall while in SPLIT
    set_a(1'b1, ADD, 5'd3, 32'h800);
    set_b(1'b1, ADD, 5'd3, 5'd0, 5'd12, 32'h804);
    tick;
    check("sf_count", split_count, 4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("sf_stall_a_pc", ex_a_pc, 32'h800);
      check("sf_stall_b_valid", ex_b_valid, 0);
    end
    flush = 1'b1;
    #1 check("sf_flush_hold", id_hold, 0);
    tick;
    check("sf_flush_a_valid", ex_a_valid, 0);
    check("sf_flush_a_ctrl", ex_a_ctrl, 0);
    check("sf_flush_b_valid", ex_b_valid, 0);
    check("sf_flush_b_ctrl", ex_b_ctrl, 0);
    flush = 1'b0; stall = 1'b0;
    set_a(1'b1, ADD, 5'd1, 32'h900);
    set_b(1'b1, ADD, 5'd2, 5'd2, 5'd2, 32'h904);
    tick;
    check("sf_after_a_pc", ex_a_pc, 32'h900);
    check("sf_after_b_valid", ex_b_valid, 1);
    check("sf_after_count", split_count, 4);
    // id_hold gating by stall and flush in PAIR
    set_a(1'b1, ADD, 5'd5, 32'hA00);
    set_b(1'b1, ADD, 5'd0, 5'd5, 5'd6, 32'hA04);
    stall = 1'b1;
    #1 check("gate_stall_hold", id_hold, 0);
    stall = 1'b0; flush = 1'b1;
    #1 check("gate_flush_hold", id_hold, 0);
    flush = 1'b0;
    #1 check("gate_none_hold", id_hold, 1);
    tick;
    check("gate_count", split_count, 5);
    tick;
    check("gate_e2_a_pc", ex_a_pc, 32'hA04);
    // saturation from a preloaded count
    dut.split_count_q = 16'hFFFE;
    tick;
    check("sat_first", split_count, 16'hFFFF);
    tick;
    tick;
    check("sat_hold", split_count, 16'hFFFF);
    check("sat_a_valid", ex_a_valid, 1);
    // asynchronous reset mid-split
    reset = 1'b0;
    #1;
    check("arst_a_valid", ex_a_valid, 0);
    check("arst_a_pc", ex_a_pc, 0);
    check("arst_count", split_count, 0);
    tick;
    reset = 1'b1;
    set_a(1'b1, ADD, 5'd1, 32'hB00);
    set_b(1'b1, ADD, 5'd2, 5'd2, 5'd2, 32'hB04);
    tick;
    check("arst_after_a_pc", ex_a_pc, 32'hB00);
    check("arst_after_b_valid", ex_b_valid, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

Dual-lane ID/EX pipeline register for the 2-wide processor. It captures the per-lane control bundle produced by decode, along with operands, PC, immediate and destination, and presents them to the execute stage. When the lanes cannot execute together (a RAW dependency, two memory operations, or a control-flow instruction in lane A), it splits the pair: lane A issues first, and lane B is buffered and issues on the following cycle. It also handles the execute-stage stall and the branch/jump flush.

## Interface
- No parameters. Data width is 32, register index width is 5, control bundle width is 11.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `a_valid`, `b_valid`  in  1  lane has a real instruction (A is the older lane)
- `a_ctrl`, `b_ctrl`  in  11  control bundle. Bit order: [10] regWrite, [9] ALUSrc, [8] branch, [7] bex, [6] JP, [5] JR, [4] JAL, [3] MemRead, [2] MemWrite, [1] MemToReg, [0] setx
- `a_pc`, `b_pc`, `a_rs_data`, `a_rt_data`, `b_rs_data`, `b_rt_data`, `a_imm`, `b_imm`  in  32  per-lane payload
- `a_rd`, `b_rs`, `b_rt`  in  5  register indices used for dependency checking
- `b_rd`  in  5  lane B destination register
- `stall`  in  1  execute stage cannot accept new instructions; hold all state
- `flush`  in  1  taken branch or jump resolved; kill everything in the latch
- `ex_a_*`, `ex_b_*`  out  same widths as the inputs  registered copies of every lane field, including `valid`, `ctrl` and `rd`
- `id_hold`  out  1  combinational; upstream IF/ID must hold for one cycle
- `split_count`  out  16  saturating count of pair splits

## Operation
- State machine with two states: PAIR (reset state) and SPLIT. There is also an internal skid register that holds one copy of the lane B fields.
- The split condition is true only when `a_valid` and `b_valid` are both high and at least one of the following holds:
  - RAW dependency: `a_ctrl[10]` is set, `a_rd` is non-zero, and `a_rd` equals `b_rs` or `b_rt`.
  - Both lanes have MemRead or MemWrite set.
  - `a_ctrl` has any of bits [8:4] set (branch, bex, JP, JR, JAL).
- Update priority on each edge: reset, then `flush`, then `stall`, then normal update.
- Reset (asynchronous):
  - All `ex_*` outputs go to 0.
  - State goes to PAIR and the skid register is cleared.
  - `split_count` goes to 0.
- Flush:
  - `ex_a_valid`, `ex_b_valid` and both `ex_*_ctrl` go to 0.
  - State goes to PAIR and the skid contents are discarded.
  - `id_hold` is 0.
- Stall (without flush):
  - All `ex_*` outputs, the state, the skid register and `split_count` hold.
  - `id_hold` is 0, because upstream already holds on `stall`.
- Normal update, PAIR, split condition false:
  - Each lane's inputs are copied into the matching `ex_` lane.
- Normal update, PAIR, split condition true:
  - Lane A is copied into `ex_a`, and `ex_b` becomes a bubble.
  - Lane B is copied into the skid register and state goes to SPLIT.
  - `split_count` increments, saturating at 0xFFFF.
- Normal update, SPLIT:
  - The lane inputs are ignored; they still show the same held pair.
  - The skid contents are copied into `ex_a`, and `ex_b` becomes a bubble.
  - State goes to PAIR.
- A bubble means `valid` = 0 and `ctrl` = 0. The payload fields of a bubble are don't-care but must not be X.
- `ctrl` is always written ANDed with `valid`, so an invalid lane never carries non-zero control bits.
- `id_hold` = (state == PAIR) AND split condition AND not `stall` AND not `flush`.

## Timing
- Latency is one cycle from input to `ex_*` output for an unsplit pair.
- In a split pair, lane B appears on `ex_a` two cycles after the pair was presented, plus one cycle for every stall cycle in between.
- Stall in the SPLIT state holds the SPLIT state, for any number of cycles.
- Flush in the SPLIT state drops the buffered lane B. It does not issue.
- Flush and stall asserted in the same cycle: flush wins.
- Reset asserted mid-split returns the block to PAIR, with all outputs 0, immediately (asynchronously).
- Invalid lanes pass through as bubbles. If lane A is invalid and lane B is valid, the split condition is false and lane B issues in `ex_b`.

## Test plan
- Independent pair: A = add with rd = 3, B = add with rs = 4, rt = 5 → the next edge shows both valid, `id_hold` = 0, `split_count` = 0.
- RAW split: A has regWrite with rd = 3, B has rs = 3 → `id_hold` = 1. Edge 1: A issues, `ex_b_valid` = 0, `split_count` = 1. Edge 2: B's fields appear on `ex_a`.
- rd = 0 exemption: A has regWrite with rd = 0, B has rs = 0 → no split; both lanes issue together.
- Double memory and control flow: lw + sw → split. A = jal (ctrl[4] set) with any B → split. A = bne with B invalid → no split.
- Stall and flush in SPLIT: hold `stall` for 3 cycles while in SPLIT → outputs frozen. Then assert `flush` together with `stall` → all `ex_` valid and ctrl bits are 0, state is PAIR, and the skid lane B never appears.
- Reset and saturation: preload `split_count` to 0xFFFF with a further split → it stays at 0xFFFF. Drop `reset` low between clock edges → outputs clear at once, not at the next edge.
